// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: FSM encoding, data width, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of all data bits; odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: tick is combinational from the counter register; counter restarts the cycle after clear.
// Backpressure: none; free-running unless held in clear.
// Ports: low_Freq_Clk/reset clock and async active-low reset; clear synchronous restart;
//        tick high during the final cycle of a bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic low_Freq_Clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge low_Freq_Clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: serialises an accepted byte as start, 8 data (LSB first), optional parity, stop bits.
// Latency: line drops to the start bit on the accepting edge; frame lasts (10+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT cycles.
// Backpressure: tx_Done low while busy; strobes arriving outside IDLE are dropped.
// Ports: low_Freq_Clk clock; reset async active-low; valid_Sig/random_Byte one-cycle byte strobe;
//        tx_Serial line (idle high); tx_Done ready level; tx_Active frame in progress.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       low_Freq_Clk,
    input  logic       reset,
    input  logic       valid_Sig,
    input  logic [7:0] random_Byte,
    output logic       tx_Serial,
    output logic       tx_Done,
    output logic       tx_Active
);

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e    state, state_nxt;
    logic [7:0]     shift, shift_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic           stop_cnt, stop_cnt_nxt;
    logic           par, par_nxt;
    logic           serial_nxt, done_nxt, active_nxt;
    logic           tick;

    // Counter is held at zero while idle, so the start bit always gets a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .low_Freq_Clk(low_Freq_Clk),
        .reset       (reset),
        .clear       (state == IDLE),
        .tick        (tick)
    );

    always_ff @(posedge low_Freq_Clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            par       <= 1'b0;
            tx_Serial <= 1'b1;
            tx_Done   <= 1'b1;
            tx_Active <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            stop_cnt  <= stop_cnt_nxt;
            par       <= par_nxt;
            tx_Serial <= serial_nxt;
            tx_Done   <= done_nxt;
            tx_Active <= active_nxt;
        end
    end

    // Outputs are computed as next-state values so every output leaves a flop.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_idx_nxt  = bit_idx;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par;
        serial_nxt   = tx_Serial;
        done_nxt     = tx_Done;
        active_nxt   = tx_Active;

        case (state)
            IDLE: begin
                if (valid_Sig) begin
                    shift_nxt    = random_Byte;
                    // Parity captured up front because the shift register is consumed bit by bit.
                    par_nxt      = parity_bit(random_Byte, 1'(PARITY_ODD));
                    bit_idx_nxt  = '0;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = START;
                    serial_nxt   = 1'b0;
                    done_nxt     = 1'b0;
                    active_nxt   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt  = DATA;
                    serial_nxt = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_nxt  = PARITY;
                            serial_nxt = par;
                        end else begin
                            state_nxt  = STOP;
                            serial_nxt = 1'b1;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = shift >> 1;
                        serial_nxt  = shift[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt  = STOP;
                    serial_nxt = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_nxt  = IDLE;
                        serial_nxt = 1'b1;
                        done_nxt   = 1'b1;
                        active_nxt = 1'b0;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                serial_nxt = 1'b1;
                done_nxt   = 1'b1;
                active_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx across several parameter sets, with a per-cycle line model.
// Latency: n/a.
// Backpressure: upstream modelled as tx_Done-gated with a one-cycle registered strobe.
module tb_uart_byte_tx;

    localparam int NDUT = 5;
    // 0: defaults @4, 1: even parity @4, 2: odd parity @4, 3: two stop bits @4, 4: defaults @1
    localparam int CPB_T  [NDUT] = '{4, 4, 4, 4, 1};
    localparam int PEN_T  [NDUT] = '{0, 1, 1, 0, 0};
    localparam int PODD_T [NDUT] = '{0, 0, 1, 0, 0};
    localparam int STOP_T [NDUT] = '{1, 1, 1, 2, 1};

    logic            low_Freq_Clk = 1'b0;
    logic            reset;
    logic [NDUT-1:0] valid;
    logic [7:0]      byte_in [NDUT];
    logic [NDUT-1:0] ser, done, act;

    int checks = 0;
    int errors = 0;

    always #5 low_Freq_Clk = ~low_Freq_Clk;

    uart_byte_tx #(.CLKS_PER_BIT(CPB_T[0]), .PARITY_EN(PEN_T[0]), .PARITY_ODD(PODD_T[0]), .STOP_BITS(STOP_T[0])) dut0 (
        .low_Freq_Clk(low_Freq_Clk), .reset(reset), .valid_Sig(valid[0]), .random_Byte(byte_in[0]),
        .tx_Serial(ser[0]), .tx_Done(done[0]), .tx_Active(act[0]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB_T[1]), .PARITY_EN(PEN_T[1]), .PARITY_ODD(PODD_T[1]), .STOP_BITS(STOP_T[1])) dut1 (
        .low_Freq_Clk(low_Freq_Clk), .reset(reset), .valid_Sig(valid[1]), .random_Byte(byte_in[1]),
        .tx_Serial(ser[1]), .tx_Done(done[1]), .tx_Active(act[1]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB_T[2]), .PARITY_EN(PEN_T[2]), .PARITY_ODD(PODD_T[2]), .STOP_BITS(STOP_T[2])) dut2 (
        .low_Freq_Clk(low_Freq_Clk), .reset(reset), .valid_Sig(valid[2]), .random_Byte(byte_in[2]),
        .tx_Serial(ser[2]), .tx_Done(done[2]), .tx_Active(act[2]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB_T[3]), .PARITY_EN(PEN_T[3]), .PARITY_ODD(PODD_T[3]), .STOP_BITS(STOP_T[3])) dut3 (
        .low_Freq_Clk(low_Freq_Clk), .reset(reset), .valid_Sig(valid[3]), .random_Byte(byte_in[3]),
        .tx_Serial(ser[3]), .tx_Done(done[3]), .tx_Active(act[3]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB_T[4]), .PARITY_EN(PEN_T[4]), .PARITY_ODD(PODD_T[4]), .STOP_BITS(STOP_T[4])) dut4 (
        .low_Freq_Clk(low_Freq_Clk), .reset(reset), .valid_Sig(valid[4]), .random_Byte(byte_in[4]),
        .tx_Serial(ser[4]), .tx_Done(done[4]), .tx_Active(act[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame as a list of bit values, indexed by bit slot.
    function automatic int frame_bits(input int d);
        return 1 + 8 + PEN_T[d] + STOP_T[d];
    endfunction

    function automatic logic model_bit(input int d, input logic [7:0] b, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i <= 8) return 1'(({24'd0, b} >> (i - 1)) & 1);
        if (PEN_T[d] != 0 && i == 9) begin
            ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(({24'd0, b} >> k) & 1);
            return 1'((ones % 2) ^ PODD_T[d]);
        end
        return 1'b1;
    endfunction

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge low_Freq_Clk);
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("idle d%0d ser", i), ser[i], 1'b1);
                chk($sformatf("idle d%0d done", i), done[i], 1'b1);
                chk($sformatf("idle d%0d act", i), act[i], 1'b0);
            end
        end
    endtask

    // Starts just after a negedge; ends at the negedge after the completing edge k+N.
    // A junk strobe at slot j is presented after edge k+j and sampled at edge k+j+1.
    task automatic send(input int d, input logic [7:0] b, input int junk_a, input int junk_b,
                        output logic [15:0] line);
        int n;
        n = frame_bits(d) * CPB_T[d];
        line = '0;
        valid[d]   = 1'b1;
        byte_in[d] = b;
        @(posedge low_Freq_Clk);
        for (int j = 0; j < n; j++) begin
            @(negedge low_Freq_Clk);
            valid[d]   = (j == junk_a) || (j == junk_b);
            byte_in[d] = valid[d] ? 8'hFF : 8'($urandom);
            chk($sformatf("d%0d b%02h ser j%0d", d, b, j), ser[d], model_bit(d, b, j / CPB_T[d]));
            chk($sformatf("d%0d b%02h done j%0d", d, b, j), done[d], 1'b0);
            chk($sformatf("d%0d b%02h act j%0d", d, b, j), act[d], 1'b1);
            if (j % CPB_T[d] == 0) line[j / CPB_T[d]] = ser[d];
        end
        @(negedge low_Freq_Clk);
        valid[d] = 1'b0;
        chk($sformatf("d%0d end ser", d), ser[d], 1'b1);
        chk($sformatf("d%0d end done", d), done[d], 1'b1);
        chk($sformatf("d%0d end act", d), act[d], 1'b0);
    endtask

    initial begin
        logic [15:0] line;
        int d, n, ja, jb;

        reset = 1'b1;
        valid = '0;
        for (int i = 0; i < NDUT; i++) byte_in[i] = 8'h00;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst d%0d ser", i), ser[i], 1'b1);
            chk($sformatf("rst d%0d done", i), done[i], 1'b1);
            chk($sformatf("rst d%0d act", i), act[i], 1'b0);
        end
        repeat (2) @(negedge low_Freq_Clk);
        reset = 1'b1;
        idle_check(2);

        // Basic frame, 4 cycles per bit
        send(0, 8'hA5, -1, -1, line);
        chk("t1 line", line[9:0], 10'b1101001010);

        // Parity: even, odd, and a single set bit
        send(1, 8'hA5, -1, -1, line);
        chk("t2 even A5", line[9], 1'b0);
        send(2, 8'hA5, -1, -1, line);
        chk("t2 odd A5", line[9], 1'b1);
        send(1, 8'h01, -1, -1, line);
        chk("t2 even 01", line[9], 1'b1);

        // Strobes during a frame are dropped
        send(0, 8'h3C, 5, 20, line);
        chk("t3 line", line[9:0], 10'b1001111000);
        idle_check(3);

        // Back-to-back with one idle cycle, including a trailing strobe, and two stop bits
        send(0, 8'h00, -1, -1, line);
        send(0, 8'hFF, 0, -1, line);
        send(3, 8'h00, -1, -1, line);
        send(3, 8'hFF, 0, -1, line);
        idle_check(1);

        // Reset in the middle of the data bits
        valid[0]   = 1'b1;
        byte_in[0] = 8'h55;
        @(posedge low_Freq_Clk);
        @(negedge low_Freq_Clk);
        valid[0] = 1'b0;
        repeat (13) @(negedge low_Freq_Clk);
        chk("t5 busy before reset", done[0], 1'b0);
        reset = 1'b0;
        #1;
        chk("t5 rst ser", ser[0], 1'b1);
        chk("t5 rst done", done[0], 1'b1);
        chk("t5 rst act", act[0], 1'b0);
        @(negedge low_Freq_Clk);
        reset = 1'b1;
        idle_check(CPB_T[0] * 12);
        send(0, 8'h81, -1, -1, line);
        chk("t5 line", line[9:0], 10'b1100000010);

        // One cycle per bit
        send(4, 8'hF0, -1, -1, line);
        chk("t6 line", line[9:0], 10'b1111100000);
        idle_check(1);

        // Random bytes, instances, junk strobes and gaps
        repeat (30) begin
            d  = $urandom_range(0, NDUT - 1);
            n  = frame_bits(d) * CPB_T[d];
            ja = $urandom_range(0, n - 1);
            jb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            send(d, 8'($urandom), ja, jb, line);
            idle_check($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Serial UART transmitter, directly downstream of the parity-filter random byte generator. Consumes the generator's one-cycle valid_Sig/random_Byte strobe and serialises the byte as a standard async frame on tx_Serial. Returns the tx_Done ready level, which the generator uses to gate its next byte. Runs entirely in the low_Freq_Clk domain.

Parameters:
CLKS_PER_BIT, 16, low_Freq_Clk cycles per serial bit; legal range >= 1.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
low_Freq_Clk  input  1  block clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low.
valid_Sig  input  1  one-cycle strobe; random_Byte is valid this cycle.
random_Byte  input  8  byte to transmit.
tx_Serial  output  1  serial line; idle high.
tx_Done  output  1  ready level; high = idle and able to accept a byte.
tx_Active  output  1  high while a frame is on the line.

Interface decision: reset is named reset, asynchronous, active-low; the clock is low_Freq_Clk.

Behaviour:
- Reset values (immediate on reset low): tx_Serial=1, tx_Done=1, tx_Active=0, state=IDLE, all counters=0, shift register=0. tx_Done resets high so the upstream stage can issue its first byte.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states:
  - IDLE: idle state.
  - START: start bit.
  - DATA: data bits.
  - PARITY: entered only if PARITY_EN=1.
  - STOP: stop bits.
- Accept:
  - In IDLE, valid_Sig=1 sampled at edge k → random_Byte is latched into the shift register.
  - From edge k: state=START, tx_Serial=0, tx_Done=0, tx_Active=1.
- Bit timing:
  - Baud counter counts 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - Bit advance happens on the edge where the counter equals CLKS_PER_BIT-1; the counter wraps to 0 on that edge.
- Frame order:
  - Start bit 0.
  - 8 data bits, LSB first; a 3-bit index counts 0..7.
  - Parity bit, if enabled: XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - STOP_BITS × 1.
- Frame length: N = (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, counted from edge k.
- Completion: at edge k+N, state=IDLE, tx_Serial=1, tx_Done=1, tx_Active=0, all on the same edge.
- Back-to-back: a valid_Sig sampled at edge k+N+1 or later starts the next frame. With the upstream one-cycle registration, a 1-cycle idle-high gap results between frames.
- valid_Sig while not in IDLE: ignored; the byte is dropped and the frame in progress is unaffected. The upstream stage may emit one trailing strobe before it observes tx_Done low; that strobe must not corrupt or restart the frame.
- valid_Sig held high across several cycles in IDLE: only the first sampled cycle is accepted; further cycles are ignored until the frame ends.
- CLKS_PER_BIT=1: each bit lasts 1 cycle and N = 10 cycles with the default options.
- Reset mid-frame: the line returns high immediately, the byte is discarded, and tx_Done=1. No partial frame resumes after reset is released.
- random_Byte is sampled only at accept; changes during a frame have no effect.

Decomposition:
- Shared package uart_pkg contains:
  - state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit;
  - DATA_BITS=8;
  - a parity helper function.
- Sub-module uart_baud_tick: CLKS_PER_BIT counter with a synchronous clear input and a one-cycle tick output. The main FSM consumes the tick and clears the counter on accept.

Test Plan:
1. CLKS_PER_BIT=4, defaults; strobe 0xA5 → tx_Serial sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_Done low for exactly 40 cycles, then high.
2. PARITY_EN=1, CLKS_PER_BIT=4; 0xA5 with PARITY_ODD=0 → parity bit 0, frame 44 cycles. Same byte with PARITY_ODD=1 → parity bit 1. 0x01 with PARITY_ODD=0 → parity bit 1.
3. Send 0x3C; strobe 0xFF at cycle 5 of the frame and again at cycle 20 → only 0x3C appears on the line; no second frame starts; tx_Done rises at cycle 40.
4. Back-to-back, driven by the upstream model (tx_Done-gated, 1-cycle registered strobe): bytes 0x00 then 0xFF → two correct frames separated by exactly 1 idle-high cycle; STOP_BITS=2 → each frame is 44 cycles at CLKS_PER_BIT=4.
5. Assert reset low mid-DATA in a 0x55 frame → tx_Serial=1, tx_Done=1, tx_Active=0 immediately. After release, strobe 0x81 → a clean full frame.
6. CLKS_PER_BIT=1, strobe 0xF0 → line 0,0,0,0,0,1,1,1,1,1, one cycle per bit; tx_Done low for 10 cycles.
